// File: rtl/ip_handler_dl_pkg.sv
// Shared types and helpers for the ip_handler deadlock detection/report blocks.
package ip_handler_dl_pkg;

  localparam int unsigned DEFAULT_CONFIRM_CYCLES = 16;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

  typedef enum logic [2:0] {
    StIdle,
    StConfirm,
    StOrigin,
    StTrace,
    StReport,
    StDone
  } dl_state_e;

  // Index width for n processes; never below 1 so a single process still gets a port.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ip_handler_dl_report_ctrl_if.sv
// Deadlock report handshake: the controller drives report fields, the consumer acks.
interface ip_handler_dl_report_ctrl_if
  import ip_handler_dl_pkg::*;
#(
  parameter int unsigned PROC_NUM = 4,
  parameter int unsigned SEL_W    = sel_w(PROC_NUM)
);
  logic                report_vld;
  logic                report_rdy;
  logic [SEL_W-1:0]    report_origin;
  logic [PROC_NUM-1:0] report_chain;
  logic                report_timeout;

  modport master (
    output report_vld,
    output report_origin,
    output report_chain,
    output report_timeout,
    input  report_rdy
  );

  modport slave (
    input  report_vld,
    input  report_origin,
    input  report_chain,
    input  report_timeout,
    output report_rdy
  );
endinterface

// File: rtl/ip_handler_dl_prio_enc.sv
// Lowest-index-wins priority encoder: vector to index plus any-set flag.
module ip_handler_dl_prio_enc
  import ip_handler_dl_pkg::*;
#(
  parameter int unsigned PROC_NUM = 4,
  parameter int unsigned SEL_W    = sel_w(PROC_NUM)
) (
  input  logic [PROC_NUM-1:0] i_vec,
  output logic [SEL_W-1:0]    o_idx,
  output logic                o_vld
);

  // Scan downward so the lowest set bit is the last (winning) assignment.
  always_comb begin
    o_idx = '0;
    for (int i = int'(PROC_NUM) - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = SEL_W'(i);
    end
  end

  assign o_vld = |i_vec;

endmodule

// File: rtl/ip_handler_dl_report_ctrl.sv
// Central deadlock sequencer: confirm a local flag, elect an origin, trace the
// token round trip and present a one-shot report.
module ip_handler_dl_report_ctrl
  import ip_handler_dl_pkg::*;
#(
  parameter int unsigned PROC_NUM       = 4,
  parameter int unsigned CONFIRM_CYCLES = DEFAULT_CONFIRM_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [PROC_NUM-1:0]          i_dl_detect_vec,
  input  logic [PROC_NUM-1:0]          i_proc_token_vec,
  input  logic                         i_clear,
  output logic [PROC_NUM-1:0]          o_origin_vec,
  output logic [PROC_NUM-1:0]          o_token_clear_vec,
  output logic                         o_dl_detect_global,
  output logic                         o_deadlock,
  ip_handler_dl_report_ctrl_if.master  report_if
);

  localparam int unsigned SEL_W   = sel_w(PROC_NUM);
  localparam int unsigned CNT_MAX = (CONFIRM_CYCLES > TIMEOUT_CYCLES) ? CONFIRM_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  dl_state_e           r_state;
  logic [SEL_W-1:0]    r_sel;
  logic [CNT_W-1:0]    r_cnt;
  logic [PROC_NUM-1:0] r_chain;
  logic                r_timeout;
  logic                r_deadlock;
  logic [PROC_NUM-1:0] r_origin_vec;
  logic                r_dl_global;
  logic                r_report_vld;

  logic [SEL_W-1:0]    w_arb_idx;
  logic                w_arb_vld;
  logic [PROC_NUM-1:0] w_sel_onehot;
  logic                w_return;
  logic                w_confirm_done;
  logic                w_timeout_hit;

  ip_handler_dl_prio_enc #(
    .PROC_NUM (PROC_NUM),
    .SEL_W    (SEL_W)
  ) u_prio_enc (
    .i_vec (i_dl_detect_vec),
    .o_idx (w_arb_idx),
    .o_vld (w_arb_vld)
  );

  assign w_sel_onehot   = PROC_NUM'(1) << r_sel;
  assign w_return       = i_proc_token_vec[r_sel] & i_dl_detect_vec[r_sel];
  assign w_confirm_done = (r_cnt == CNT_W'(CONFIRM_CYCLES - 1));
  assign w_timeout_hit  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Token clear must hit the origin in the very cycle the return is seen.
  always_comb begin
    o_token_clear_vec = '0;
    if (r_state == StTrace && !i_clear && (w_return || w_timeout_hit)) begin
      o_token_clear_vec = w_sel_onehot;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_sel        <= '0;
      r_cnt        <= '0;
      r_chain      <= '0;
      r_timeout    <= 1'b0;
      r_deadlock   <= 1'b0;
      r_origin_vec <= '0;
      r_dl_global  <= 1'b0;
      r_report_vld <= 1'b0;
    end else begin
      r_origin_vec <= '0;
      if (i_clear) begin
        r_state      <= StIdle;
        r_sel        <= '0;
        r_cnt        <= '0;
        r_chain      <= '0;
        r_timeout    <= 1'b0;
        r_deadlock   <= 1'b0;
        r_dl_global  <= 1'b0;
        r_report_vld <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_arb_vld) begin
              r_sel   <= w_arb_idx;
              r_cnt   <= '0;
              r_state <= StConfirm;
            end
          end
          StConfirm: begin
            if (!i_dl_detect_vec[r_sel]) begin
              r_cnt   <= '0;
              r_state <= StIdle;
            end else if (w_confirm_done) begin
              r_cnt        <= '0;
              r_origin_vec <= w_sel_onehot;
              r_dl_global  <= 1'b1;
              r_state      <= StOrigin;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          StOrigin: begin
            r_chain   <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_state   <= StTrace;
          end
          StTrace: begin
            r_chain <= r_chain | i_proc_token_vec;
            r_cnt   <= r_cnt + 1'b1;
            // A return in the timeout cycle still counts as a clean return.
            if (w_return || w_timeout_hit) begin
              r_timeout    <= ~w_return;
              r_deadlock   <= 1'b1;
              r_report_vld <= 1'b1;
              r_state      <= StReport;
            end
          end
          StReport: begin
            if (report_if.report_rdy) begin
              r_report_vld <= 1'b0;
              r_state      <= StDone;
            end
          end
          StDone: begin
            r_state <= StDone;
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

  assign o_origin_vec             = r_origin_vec;
  assign o_dl_detect_global       = r_dl_global;
  assign o_deadlock               = r_deadlock;
  assign report_if.report_vld     = r_report_vld;
  assign report_if.report_origin  = r_sel;
  assign report_if.report_chain   = r_chain;
  assign report_if.report_timeout = r_timeout;

endmodule
